// File: rtl/alu_pkg.sv
// Shared definitions for the alu issue/writeback slice: opcodes, flag bit indices, FSM states.
package alu_pkg;
  localparam int DATA_W = 16;

  localparam logic [3:0] ADD   = 4'd0;
  localparam logic [3:0] SUB   = 4'd1;
  localparam logic [3:0] AND   = 4'd2;
  localparam logic [3:0] OR    = 4'd3;
  localparam logic [3:0] XOR   = 4'd4;
  localparam logic [3:0] NOT   = 4'd5;
  localparam logic [3:0] SHL   = 4'd6;
  localparam logic [3:0] SHR   = 4'd7;
  localparam logic [3:0] CMPEQ = 4'd8;
  localparam logic [3:0] CMPLT = 4'd9;
  localparam logic [3:0] CMPLE = 4'd10;
  localparam logic [3:0] MUL   = 4'd11;

  localparam int ZF = 2;
  localparam int CF = 1;
  localparam int VF = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_e;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction issue handshake bundle. ALU_IMM_EN adds the immediate-operand fields.
interface alu_issue_ctrl_if #(parameter int ADDR_W = 3);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
`ifdef ALU_IMM_EN
  logic              instr_use_imm;
  logic [15:0]       instr_imm;

  modport master (output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
                         instr_use_imm, instr_imm,
                  input  instr_ready);
  modport slave  (input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
                         instr_use_imm, instr_imm,
                  output instr_ready);
`else
  modport master (output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
                  input  instr_ready);
  modport slave  (input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
                  output instr_ready);
`endif
endinterface

// File: rtl/alu_regfile.sv
// Register file: two operand read ports, one combinational debug port, one write port.
// R0 is never written, so it reads back as zero on every port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_REGS)-1:0] ra_addr,
  input  logic [$clog2(NUM_REGS)-1:0] rb_addr,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           ra_data,
  output logic [DATA_W-1:0]           rb_data,
  output logic [DATA_W-1:0]           dbg_data,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] wa,
  input  logic [DATA_W-1:0]           wd
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      regs <= '0;
    else if (we && (wa != '0))
      regs[wa] <= wd;
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 16-bit alu: IDLE accept -> EXEC (alu_enable) -> WB.
// Optional immediate operand B when ALU_IMM_EN is defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_issue_ctrl_if.slave      instr,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [3:0]           alu_op,
  output logic                 alu_enable,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  output logic [2:0]           flags,
  output logic                 wb_valid,
  output logic [ADDR_W-1:0]    wb_addr,
  output logic [DATA_W-1:0]    wb_data,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]    dbg_data,
  output logic                 busy
);
  state_e            state, state_nxt;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] ra_data, rb_data, opb;
  logic              accept;

  alu_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra_addr  (instr.instr_rs1),
    .rb_addr  (instr.instr_rs2),
    .dbg_addr (dbg_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data),
    .we       (wb_valid),
    .wa       (rd_q),
    .wd       (alu_result)
  );

`ifdef ALU_IMM_EN
  assign opb = instr.instr_use_imm ? instr.instr_imm : rb_data;
`else
  assign opb = rb_data;
`endif

  assign accept = instr.instr_valid && instr.instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    instr.instr_ready = 1'b0;
    alu_enable        = 1'b0;
    wb_valid          = 1'b0;
    case (state)
      ST_IDLE: begin
        instr.instr_ready = 1'b1;
        if (instr.instr_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        alu_enable = 1'b1;
        state_nxt  = ST_WB;
      end
      ST_WB: begin
        wb_valid  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands are captured at accept so the ALU sees stable inputs while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      rd_q  <= '0;
      flags <= 3'b100;
    end else begin
      if (accept) begin
        alu_a  <= ra_data;
        alu_b  <= opb;
        alu_op <= instr.instr_op;
        rd_q   <= instr.instr_rd;
      end
      if (wb_valid) begin
        flags[ZF] <= alu_zero;
        flags[CF] <= alu_carry;
        flags[VF] <= alu_overflow;
      end
    end
  end

  assign wb_addr = rd_q;
  assign wb_data = alu_result;
  assign busy    = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU + register-file model, directed and random stimulus.
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  localparam int NR = 8;
  localparam int AW = $clog2(NR);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic [3:0]    alu_op;
  logic          alu_enable, alu_zero, alu_carry, alu_overflow, wb_valid, busy;
  logic [2:0]    flags;
  logic [AW-1:0] wb_addr, dbg_addr;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.ADDR_W(AW)) ibus ();

  alu_issue_ctrl #(.NUM_REGS(NR)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (ibus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_enable   (alu_enable),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .flags        (flags),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .busy         (busy)
  );

  // ALU behaviour: returns {result, zero, carry, overflow}; carry on SUB is the borrow.
  function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op);
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      ADD:   begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                   v = (a[15] == b[15]) && (r[15] != a[15]); end
      SUB:   begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
                   v = (a[15] != b[15]) && (r[15] != a[15]); end
      AND:   r = a & b;
      OR:    r = a | b;
      XOR:   r = a ^ b;
      NOT:   r = ~a;
      SHL:   begin r = a << 1; c = a[15]; end
      SHR:   begin r = a >> 1; c = a[0]; end
      CMPEQ: r = {15'd0, a == b};
      CMPLT: r = {15'd0, $signed(a) <  $signed(b)};
      CMPLE: r = {15'd0, $signed(a) <= $signed(b)};
      MUL:   begin p = a * b; r = p[15:0]; end
      default: r = '0;
    endcase
    return {r, (r == 16'd0), c, v};
  endfunction

  // Registered ALU stand-in, held in reset with the controller.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) {alu_result, alu_zero, alu_carry, alu_overflow} <= '0;
    else if (alu_enable) {alu_result, alu_zero, alu_carry, alu_overflow} <= alu_fn(alu_a, alu_b, alu_op);

  // Reference model: register array, flags, and how many edges since the last accept.
  logic [15:0]   m_reg [NR];
  logic [2:0]    m_flags;
  int            m_phase;
  logic [3:0]    m_op;
  logic [AW-1:0] m_rd;
  logic [15:0]   m_a, m_b;
  logic [18:0]   m_exp;
  assign m_exp = alu_fn(m_a, m_b, m_op);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) m_reg[i] <= '0;
      m_flags <= 3'b100; m_phase <= 0; m_op <= '0; m_rd <= '0; m_a <= '0; m_b <= '0;
    end else if (m_phase == 0) begin
      if (ibus.instr_valid) begin
        m_phase <= 1;
        m_op    <= ibus.instr_op;
        m_rd    <= ibus.instr_rd;
        m_a     <= m_reg[ibus.instr_rs1];
`ifdef ALU_IMM_EN
        m_b     <= ibus.instr_use_imm ? ibus.instr_imm : m_reg[ibus.instr_rs2];
`else
        m_b     <= m_reg[ibus.instr_rs2];
`endif
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else begin
      if (m_rd != '0) m_reg[m_rd] <= m_exp[18:3];
      m_flags <= m_exp[2:0];
      m_phase <= 0;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int n_acc = 0, n_en = 0, n_wb = 0, n_rdylo = 0;
  logic [AW-1:0] last_wb_addr;
  logic [15:0]   last_wb_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle compare against the model, plus event counters for directed checks.
  initial forever begin
    @(negedge clk);
    chk("instr_ready", 32'(ibus.instr_ready), 32'(m_phase == 0));
    chk("busy",        32'(busy),             32'(m_phase != 0));
    chk("alu_enable",  32'(alu_enable),       32'(m_phase == 1));
    chk("wb_valid",    32'(wb_valid),         32'(m_phase == 2));
    chk("flags",       32'(flags),            32'(m_flags));
    chk("alu_a",       32'(alu_a),            32'(m_a));
    chk("alu_b",       32'(alu_b),            32'(m_b));
    chk("alu_op",      32'(alu_op),           32'(m_op));
    chk("dbg_data",    32'(dbg_data),         32'(m_reg[dbg_addr]));
    if (m_phase == 2) begin
      chk("wb_addr", 32'(wb_addr), 32'(m_rd));
      chk("wb_data", 32'(wb_data), 32'(m_exp[18:3]));
    end
    if (ibus.instr_valid && ibus.instr_ready) n_acc++;
    if (!ibus.instr_ready) n_rdylo++;
    if (alu_enable) n_en++;
    if (wb_valid) begin
      n_wb++;
      last_wb_addr = wb_addr;
      last_wb_data = wb_data;
    end
  end

  // Called at posedge+2 in IDLE; returns at posedge+2 back in IDLE.
  task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2);
    ibus.instr_valid = 1'b1;
    ibus.instr_op    = op;
    ibus.instr_rd    = AW'(rd);
    ibus.instr_rs1   = AW'(rs1);
    ibus.instr_rs2   = AW'(rs2);
    @(posedge clk); #2;
    ibus.instr_valid = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
  endtask

  task automatic dbg_chk(input string nm, input int addr, input logic [15:0] exp);
    dbg_addr = AW'(addr);
    #1;
    chk(nm, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    int w0, a0, e0, r0;
    reset_n = 1'b1;
    ibus.instr_valid = 1'b0;
    ibus.instr_op = '0; ibus.instr_rd = '0; ibus.instr_rs1 = '0; ibus.instr_rs2 = '0;
`ifdef ALU_IMM_EN
    ibus.instr_use_imm = 1'b0; ibus.instr_imm = '0;
`endif
    dbg_addr = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #2;

    chk("reset_ready", 32'(ibus.instr_ready), 32'd1);
    chk("reset_busy",  32'(busy), 32'd0);
    chk("reset_flags", 32'(flags), 32'b100);
    for (int i = 0; i < NR; i++) dbg_chk("reset_dbg", i, 16'h0000);

    issue(NOT, 1, 0, 0);
    dbg_chk("not_r1", 1, 16'hFFFF);
    chk("not_flags", 32'(flags), 32'b000);
    chk("model_r1", 32'(m_reg[1]), 32'hFFFF);

    issue(ADD, 2, 1, 1);
    dbg_chk("add_r2", 2, 16'hFFFE);
    chk("add_carry", 32'(flags[CF]), 32'd1);
    chk("model_r2", 32'(m_reg[2]), 32'hFFFE);

    issue(SUB, 3, 0, 1);
    dbg_chk("sub_r3", 3, 16'h0001);
    chk("sub_carry", 32'(flags[CF]), 32'd1);

    w0 = n_wb;
    issue(NOT, 0, 0, 0);
    chk("r0_wb_pulses", 32'(n_wb - w0), 32'd1);
    chk("r0_wb_addr", 32'(last_wb_addr), 32'd0);
    chk("r0_wb_data", 32'(last_wb_data), 32'hFFFF);
    dbg_chk("r0_stays0", 0, 16'h0000);

    a0 = n_acc; e0 = n_en; r0 = n_rdylo;
    ibus.instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ibus.instr_op  = 4'(i % 12);
      ibus.instr_rd  = AW'($urandom_range(1, NR - 1));
      ibus.instr_rs1 = AW'($urandom);
      ibus.instr_rs2 = AW'($urandom);
      @(posedge clk); #2;
    end
    ibus.instr_valid = 1'b0;
    chk("hs_accepts", 32'(n_acc - a0), 32'd3);
    chk("hs_enables", 32'(n_en - e0), 32'd3);
    chk("hs_ready_low", 32'(n_rdylo - r0), 32'd6);

    w0 = n_wb;
    ibus.instr_valid = 1'b1; ibus.instr_op = NOT;
    ibus.instr_rd = AW'(5); ibus.instr_rs1 = '0; ibus.instr_rs2 = '0;
    @(posedge clk); #2;
    ibus.instr_valid = 1'b0;
    chk("midop_in_exec", 32'(alu_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midop_busy", 32'(busy), 32'd0);
    chk("midop_wb", 32'(wb_valid), 32'd0);
    chk("midop_flags", 32'(flags), 32'b100);
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    chk("midop_no_wb", 32'(n_wb - w0), 32'd0);
    dbg_chk("midop_r5", 5, 16'h0000);

`ifdef ALU_IMM_EN
    ibus.instr_use_imm = 1'b1; ibus.instr_imm = 16'h1234;
    issue(ADD, 4, 0, 7);
    ibus.instr_use_imm = 1'b0;
    dbg_chk("imm_r4", 4, 16'h1234);
    chk("imm_flags", 32'(flags), 32'b000);
`endif

    repeat (600) begin
      ibus.instr_valid = ($urandom_range(0, 3) != 0);
      ibus.instr_op    = 4'($urandom_range(0, 15));
      ibus.instr_rd    = AW'($urandom);
      ibus.instr_rs1   = AW'($urandom);
      ibus.instr_rs2   = AW'($urandom);
`ifdef ALU_IMM_EN
      ibus.instr_use_imm = 1'($urandom);
      ibus.instr_imm     = 16'($urandom);
`endif
      dbg_addr = AW'($urandom);
      @(posedge clk); #2;
    end
    ibus.instr_valid = 1'b0;
    repeat (3) begin @(posedge clk); #2; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
